// File: rtl/rocc_unit.sv
// RoCC execute-stage responder: forwards one custom instruction to an accelerator and returns its result.
// Optional response timeout is enabled by defining ROCC_TIMEOUT_EN.
module rocc_unit #(
   parameter int unsigned TRANS_ID_BITS  = 3,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     flush_i,
   input  logic                     rocc_valid_i,
   output logic                     rocc_ready_o,
   input  logic [31:0]              rocc_instr_i,
   input  logic [63:0]              rs1_i,
   input  logic [63:0]              rs2_i,
   input  logic [TRANS_ID_BITS-1:0] trans_id_i,
   output logic                     cmd_valid_o,
   input  logic                     cmd_ready_i,
   output logic [31:0]              cmd_instr_o,
   output logic [63:0]              cmd_rs1_o,
   output logic [63:0]              cmd_rs2_o,
   input  logic                     resp_valid_i,
   output logic                     resp_ready_o,
   input  logic [63:0]              resp_data_i,
   output logic                     rocc_wb_valid_o,
   output logic [TRANS_ID_BITS-1:0] rocc_trans_id_o,
   output logic [63:0]              rocc_result_o,
   output logic                     rocc_ex_valid_o,
   output logic                     busy_o
);

   typedef enum logic [1:0] {IDLE, CMD, WAIT_RESP, DRAIN} state_e;

   state_e                   state_q;
   logic [31:0]              instr_q;
   logic [63:0]              rs1_q;
   logic [63:0]              rs2_q;
   logic [TRANS_ID_BITS-1:0] tag_q;
   logic                     xd_q;
   logic                     cmd_valid_q;
   logic                     busy_q;
   logic                     wb_valid_q;
   logic                     ex_valid_q;
   logic [63:0]              result_q;
   logic [TRANS_ID_BITS-1:0] wb_tag_q;
   logic                     accept;
   logic                     cmd_fire;
   logic                     tmo_hit;

   assign rocc_ready_o = (state_q == IDLE) && !flush_i;
   assign resp_ready_o = (state_q == WAIT_RESP) || (state_q == DRAIN);
   assign accept       = rocc_valid_i && rocc_ready_o;
   assign cmd_fire     = cmd_valid_q && cmd_ready_i;

`ifdef ROCC_TIMEOUT_EN
   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [CNT_W-1:0] tmo_cnt_q;

   // Counter sits at zero outside WAIT_RESP, so it reads 0 on the first waiting cycle.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         tmo_cnt_q <= '0;
      end else if (state_q != WAIT_RESP) begin
         tmo_cnt_q <= '0;
      end else begin
         tmo_cnt_q <= tmo_cnt_q + 1'b1;
      end
   end

   assign tmo_hit = (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   assign tmo_hit = 1'b0;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         instr_q     <= '0;
         rs1_q       <= '0;
         rs2_q       <= '0;
         tag_q       <= '0;
         xd_q        <= 1'b0;
         cmd_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         wb_valid_q  <= 1'b0;
         ex_valid_q  <= 1'b0;
         result_q    <= '0;
         wb_tag_q    <= '0;
      end else begin
         wb_valid_q <= 1'b0;
         ex_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  instr_q     <= rocc_instr_i;
                  rs1_q       <= rs1_i;
                  rs2_q       <= rs2_i;
                  tag_q       <= trans_id_i;
                  xd_q        <= rocc_instr_i[14];
                  cmd_valid_q <= 1'b1;
                  busy_q      <= 1'b1;
                  state_q     <= CMD;
               end
            end
            CMD: begin
               // A handshake takes priority over a flush in the same cycle.
               if (cmd_fire) begin
                  cmd_valid_q <= 1'b0;
                  if (xd_q) begin
                     state_q <= flush_i ? DRAIN : WAIT_RESP;
                  end else begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                     if (!flush_i) begin
                        wb_valid_q <= 1'b1;
                        result_q   <= '0;
                        wb_tag_q   <= tag_q;
                     end
                  end
               end else if (flush_i) begin
                  cmd_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            WAIT_RESP: begin
               if (resp_valid_i) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  if (!flush_i) begin
                     wb_valid_q <= 1'b1;
                     result_q   <= resp_data_i;
                     wb_tag_q   <= tag_q;
                  end
               end else if (flush_i) begin
                  state_q <= DRAIN;
               end else if (tmo_hit) begin
                  wb_valid_q <= 1'b1;
                  ex_valid_q <= 1'b1;
                  result_q   <= {32'b0, instr_q};
                  wb_tag_q   <= tag_q;
                  state_q    <= DRAIN;
               end
            end
            DRAIN: begin
               if (resp_valid_i) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign cmd_valid_o     = cmd_valid_q;
   assign cmd_instr_o     = instr_q;
   assign cmd_rs1_o       = rs1_q;
   assign cmd_rs2_o       = rs2_q;
   assign rocc_wb_valid_o = wb_valid_q;
   assign rocc_ex_valid_o = ex_valid_q;
   assign rocc_result_o   = result_q;
   assign rocc_trans_id_o = wb_tag_q;
   assign busy_o          = busy_q;

endmodule

// File: tb/tb_rocc_unit.sv
// Self-checking bench for rocc_unit: directed scenarios plus randomized transactions
// checked against a transaction-level model of the issue/command/response protocol.
module tb_rocc_unit;
   localparam int TID = 3;
   localparam int TMO = 8;
   localparam int M_NORMAL    = 0;
   localparam int M_FLUSH_CMD = 1;
   localparam int M_FLUSH_HS  = 2;
   localparam int M_FLUSH_WT  = 3;
   localparam int M_FLUSH_RSP = 4;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           flush = 1'b0;
   logic           rocc_valid = 1'b0;
   logic [31:0]    rocc_instr = '0;
   logic [63:0]    rs1 = '0;
   logic [63:0]    rs2 = '0;
   logic [TID-1:0] tid = '0;
   logic           cmd_ready = 1'b0;
   logic           resp_valid = 1'b0;
   logic [63:0]    resp_data = '0;
   logic           rocc_ready, cmd_valid, resp_ready, wb_valid, ex_valid, busy;
   logic [31:0]    cmd_instr;
   logic [63:0]    cmd_rs1, cmd_rs2, result;
   logic [TID-1:0] wb_tag;

   int checks = 0;
   int failures = 0;

   rocc_unit #(.TRANS_ID_BITS(TID), .TIMEOUT_CYCLES(TMO)) dut (
      .clk_i(clk), .rst_i(rst), .flush_i(flush),
      .rocc_valid_i(rocc_valid), .rocc_ready_o(rocc_ready), .rocc_instr_i(rocc_instr),
      .rs1_i(rs1), .rs2_i(rs2), .trans_id_i(tid),
      .cmd_valid_o(cmd_valid), .cmd_ready_i(cmd_ready), .cmd_instr_o(cmd_instr),
      .cmd_rs1_o(cmd_rs1), .cmd_rs2_o(cmd_rs2),
      .resp_valid_i(resp_valid), .resp_ready_o(resp_ready), .resp_data_i(resp_data),
      .rocc_wb_valid_o(wb_valid), .rocc_trans_id_o(wb_tag), .rocc_result_o(result),
      .rocc_ex_valid_o(ex_valid), .busy_o(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   // One instruction through the unit; expectations follow from the mode and instr[14].
   task automatic txn(input int mode, input logic [31:0] ins, input logic [TID-1:0] tg,
                      input logic [63:0] a, input logic [63:0] b, input int cw, input int rw);
      logic        xd;
      logic        drain;
      logic        exp_wb;
      logic [63:0] d;
      xd = ins[14];
      chk("idle_ready", rocc_ready, 1);
      rocc_valid = 1; rocc_instr = ins; rs1 = a; rs2 = b; tid = tg;
      tick();
      rocc_valid = 0; rocc_instr = $urandom; rs1 = rnd64(); rs2 = rnd64(); tid = TID'($urandom);
      chk("cmd_valid_t1", cmd_valid, 1);
      chk("cmd_instr", cmd_instr, ins);
      chk("cmd_rs1", cmd_rs1, a);
      chk("cmd_rs2", cmd_rs2, b);
      chk("busy_cmd", busy, 1);
      chk("ready_in_cmd", rocc_ready, 0);
      if (mode == M_FLUSH_CMD) begin
         flush = 1; cmd_ready = 0;
         tick();
         flush = 0;
         chk("flush_cmd_valid", cmd_valid, 0);
         chk("flush_cmd_busy", busy, 0);
         chk("flush_cmd_wb", wb_valid, 0);
         tick();
         chk("flush_cmd_wb2", wb_valid, 0);
         return;
      end
      for (int i = 0; i < cw; i++) begin
         cmd_ready = 0; resp_valid = 1'($urandom); resp_data = rnd64();
         tick();
         chk("cmd_hold_valid", cmd_valid, 1);
         chk("cmd_hold_instr", cmd_instr, ins);
         chk("cmd_hold_rs1", cmd_rs1, a);
         chk("cmd_hold_rs2", cmd_rs2, b);
         chk("resp_ready_cmd", resp_ready, 0);
         chk("wb_in_cmd", wb_valid, 0);
      end
      resp_valid = 0;
      cmd_ready = 1; flush = (mode == M_FLUSH_HS);
      tick();
      cmd_ready = 0; flush = 0;
      chk("cmd_drop", cmd_valid, 0);
      if (!xd) begin
         exp_wb = (mode != M_FLUSH_HS);
         chk("xd0_wb", wb_valid, exp_wb);
         if (exp_wb) begin
            chk("xd0_result", result, 0);
            chk("xd0_tag", wb_tag, tg);
            chk("xd0_ex", ex_valid, 0);
         end
         chk("xd0_busy", busy, 0);
         chk("xd0_resp_ready", resp_ready, 0);
         tick();
         chk("xd0_wb_single", wb_valid, 0);
         return;
      end
      drain = (mode == M_FLUSH_HS);
      chk("wait_resp_ready", resp_ready, 1);
      chk("wait_busy", busy, 1);
      for (int i = 0; i < rw; i++) begin
         tick();
         chk("wait_no_wb", wb_valid, 0);
         chk("wait_resp_ready_hold", resp_ready, 1);
      end
      if (!drain && mode == M_FLUSH_RSP) begin
         flush = 1; resp_valid = 1; resp_data = rnd64();
         tick();
         flush = 0; resp_valid = 0;
         chk("flush_rsp_wb", wb_valid, 0);
         chk("flush_rsp_busy", busy, 0);
         chk("flush_rsp_resp_ready", resp_ready, 0);
         tick();
         chk("flush_rsp_wb2", wb_valid, 0);
         return;
      end
      if (!drain && mode == M_FLUSH_WT) begin
         flush = 1;
         tick();
         flush = 0;
         drain = 1;
         chk("flush_wait_wb", wb_valid, 0);
         chk("drain_resp_ready", resp_ready, 1);
      end
      d = drain ? 64'hFF : rnd64();
      resp_valid = 1; resp_data = d;
      tick();
      resp_valid = 0;
      chk("resp_wb", wb_valid, !drain);
      if (!drain) begin
         chk("resp_result", result, d);
         chk("resp_tag", wb_tag, tg);
         chk("resp_ex", ex_valid, 0);
      end
      chk("resp_busy", busy, 0);
      chk("resp_ready_after", resp_ready, 0);
      chk("ready_at_wb", rocc_ready, 1);
      tick();
      chk("resp_wb_single", wb_valid, 0);
   endtask

   initial begin
      logic [31:0] i2;
      logic [63:0] a2;
      // Reset state
      tick(); tick();
      chk("rst_cmd_valid", cmd_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_wb", wb_valid, 0);
      chk("rst_result", result, 0);
      chk("rst_ready_in_reset", resp_ready, 0);
      rst = 0;
      tick();

      // Basic xd=1 latency, xd=0 with backpressure, flush cases
      txn(M_NORMAL, 32'h0020C00B, 3'd3, 64'd5, 64'd7, 0, 2);
      txn(M_NORMAL, 32'h0020800B, 3'd5, rnd64(), rnd64(), 3, 0);
      txn(M_FLUSH_CMD, 32'h0020C00B, 3'd4, rnd64(), rnd64(), 0, 0);
      txn(M_FLUSH_HS, 32'h0020C00B, 3'd6, rnd64(), rnd64(), 1, 1);
      txn(M_FLUSH_WT, 32'h0020C00B, 3'd2, rnd64(), rnd64(), 0, 1);
      txn(M_FLUSH_RSP, 32'h0020C00B, 3'd1, rnd64(), rnd64(), 0, 0);

      // Back-to-back: second instruction held while the first is in flight
      rocc_valid = 1; rocc_instr = 32'h0000400B; rs1 = 64'hA1; rs2 = 64'hB1; tid = 3'd1;
      tick();
      i2 = 32'h0000600B; a2 = rnd64();
      rocc_instr = i2; rs1 = a2; rs2 = 64'hB2; tid = 3'd2;
      chk("b2b_first_rs1", cmd_rs1, 64'hA1);
      chk("b2b_ready_cmd", rocc_ready, 0);
      cmd_ready = 1;
      tick();
      cmd_ready = 0;
      chk("b2b_ready_wait", rocc_ready, 0);
      tick();
      resp_valid = 1; resp_data = 64'h1111;
      tick();
      resp_valid = 0;
      chk("b2b_wb1", wb_valid, 1);
      chk("b2b_tag1", wb_tag, 1);
      chk("b2b_res1", result, 64'h1111);
      chk("b2b_ready_at_wb", rocc_ready, 1);
      tick();
      rocc_valid = 0;
      chk("b2b_wb1_single", wb_valid, 0);
      chk("b2b_second_cmd", cmd_valid, 1);
      chk("b2b_second_instr", cmd_instr, i2);
      chk("b2b_second_rs1", cmd_rs1, a2);
      cmd_ready = 1;
      tick();
      cmd_ready = 0;
      resp_valid = 1; resp_data = 64'h2222;
      tick();
      resp_valid = 0;
      chk("b2b_wb2", wb_valid, 1);
      chk("b2b_tag2", wb_tag, 2);
      chk("b2b_res2", result, 64'h2222);
      tick();

      // Asynchronous reset while waiting for a response
      rocc_valid = 1; rocc_instr = 32'h0000C00B; rs1 = rnd64(); rs2 = rnd64(); tid = 3'd7;
      tick();
      rocc_valid = 0; cmd_ready = 1;
      tick();
      cmd_ready = 0;
      chk("rstw_in_wait", resp_ready, 1);
      #2 rst = 1;
      #1;
      chk("rstw_cmd_instr", cmd_instr, 0);
      chk("rstw_cmd_rs1", cmd_rs1, 0);
      chk("rstw_busy", busy, 0);
      chk("rstw_resp_ready", resp_ready, 0);
      chk("rstw_result", result, 0);
      chk("rstw_tag", wb_tag, 0);
      chk("rstw_ex", ex_valid, 0);
      tick();
      rst = 0;
      resp_valid = 1; resp_data = 64'hDEAD;
      chk("rstw_late_resp_ready", resp_ready, 0);
      tick();
      resp_valid = 0;
      chk("rstw_late_wb", wb_valid, 0);
      chk("rstw_late_busy", busy, 0);
      tick();

      // Response timeout
      rocc_valid = 1; rocc_instr = 32'h1234C00B; rs1 = rnd64(); rs2 = rnd64(); tid = 3'd5;
      tick();
      rocc_valid = 0; cmd_ready = 1;
      tick();
      cmd_ready = 0;
`ifdef ROCC_TIMEOUT_EN
      for (int i = 1; i < TMO; i++) begin
         tick();
         chk("tmo_early_wb", wb_valid, 0);
      end
      tick();
      chk("tmo_wb", wb_valid, 1);
      chk("tmo_ex", ex_valid, 1);
      chk("tmo_result", result, 64'h1234C00B);
      chk("tmo_tag", wb_tag, 5);
      chk("tmo_drain_ready", resp_ready, 1);
      resp_valid = 1; resp_data = 64'h55;
      tick();
      resp_valid = 0;
      chk("tmo_late_wb", wb_valid, 0);
      chk("tmo_late_busy", busy, 0);
`else
      for (int i = 0; i < 3 * TMO; i++) tick();
      chk("notmo_wb", wb_valid, 0);
      chk("notmo_ex", ex_valid, 0);
      chk("notmo_waiting", resp_ready, 1);
      resp_valid = 1; resp_data = 64'h55;
      tick();
      resp_valid = 0;
      chk("notmo_wb_resp", wb_valid, 1);
      chk("notmo_result", result, 64'h55);
      chk("notmo_tag", wb_tag, 5);
`endif
      tick();

      // Randomized transactions
      for (int n = 0; n < 60; n++) begin
         txn(int'($urandom_range(0, 4)), $urandom, TID'($urandom), rnd64(), rnd64(),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 4)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
